// File: rtl/tetris_input_pkg.sv
// Shared constants and types for the tetris push-button conditioning stage.
package tetris_input_pkg;

  localparam int unsigned NUM_KEYS   = 3;
  localparam int unsigned KEY_RIGHT  = 0;
  localparam int unsigned KEY_LEFT   = 1;
  localparam int unsigned KEY_ROTATE = 2;

  // Defaults assume a 50 MHz clock: 5 ms debounce, 160 ms delay, 50 ms repeat.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned DAS_CYCLES_DEF      = 8000000;
  localparam int unsigned ARR_CYCLES_DEF      = 2500000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DAS,
    RPT_ARR
  } rpt_state_e;

endpackage

// File: rtl/key_debounce.sv
// One active-low button: two-flop synchroniser, stability counter and press-edge detector.
module key_debounce #(
  parameter int unsigned DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic held_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  logic            sync1_q, sync2_q;
  logic            state_q, state_d, state_dly_q, press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle on which the synchronised level agrees with the accepted one restarts the count.
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (~sync2_q != state_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= 1'b0;
      state_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_ni;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      state_dly_q <= state_q;
      press_q     <= state_q & ~state_dly_q;
    end
  end

  assign held_o  = state_q;
  assign press_o = press_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Button conditioning for the tetris FSM: debounce, LEFT/RIGHT conflict masking and,
// when INPUT_AUTO_REPEAT_EN is defined, delayed auto-repeat on held LEFT/RIGHT.
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DAS_CYCLES      = DAS_CYCLES_DEF,
  parameter int unsigned ARR_CYCLES      = ARR_CYCLES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [2:0] key_n,
  output logic       move_left_o,
  output logic       move_right_o,
  output logic       rotate_o,
  output logic [2:0] key_held_o
);

  logic [NUM_KEYS-1:0] held, press;
  logic [1:0]          press_eff, rpt_pulse;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i  (CLOCK_50),
      .rst_ni (resetn),
      .key_ni (key_n[k]),
      .held_o (held[k]),
      .press_o(press[k])
    );
  end

  assign press_eff[KEY_RIGHT] = press[KEY_RIGHT] & ~press[KEY_LEFT];
  assign press_eff[KEY_LEFT]  = press[KEY_LEFT] & ~press[KEY_RIGHT];

`ifdef INPUT_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  // Index d doubles as the key index: 0 = RIGHT, 1 = LEFT.
  for (genvar d = 0; d < 2; d++) begin : g_rpt
    rpt_state_e      st_q, st_d;
    logic [RptW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;
    logic            hold_ok;

    assign hold_ok = held[d] & ~held[1-d];

    // The press cycle counts as the first held cycle, hence entry into DAS at 1.
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      unique case (st_q)
        RPT_IDLE: begin
          if (press_eff[d] && hold_ok) begin
            st_d  = RPT_DAS;
            cnt_d = RptW'(1);
          end
        end
        RPT_DAS: begin
          if (!hold_ok) begin
            st_d  = RPT_IDLE;
            cnt_d = '0;
          end else if (cnt_q == RptW'(DAS_CYCLES - 1)) begin
            st_d    = RPT_ARR;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + RptW'(1);
          end
        end
        RPT_ARR: begin
          if (!hold_ok) begin
            st_d  = RPT_IDLE;
            cnt_d = '0;
          end else if (cnt_q == RptW'(ARR_CYCLES - 1)) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + RptW'(1);
          end
        end
        default: begin
          st_d  = RPT_IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
        st_q    <= RPT_IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign rpt_pulse[d] = pulse_q;
  end
`else
  // Repeat timing has no effect in this build.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{DAS_CYCLES, ARR_CYCLES};
  assign rpt_pulse      = '0;
`endif

  assign move_right_o = press_eff[KEY_RIGHT] | rpt_pulse[KEY_RIGHT];
  assign move_left_o  = press_eff[KEY_LEFT] | rpt_pulse[KEY_LEFT];
  assign rotate_o     = press[KEY_ROTATE];
  assign key_held_o   = held;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed plus randomized bench for tetris_input_ctrl against a cycle-level behavioural model.
module tb_tetris_input_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned DAS = 10;
  localparam int unsigned ARR = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] key_n;
  logic       move_left, move_right, rotate;
  logic [2:0] key_held;

  always #5 clk = ~clk;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .key_n       (key_n),
    .move_left_o (move_left),
    .move_right_o(move_right),
    .rotate_o    (rotate),
    .key_held_o  (key_held)
  );

  int vectors     = 0;
  int miscompares = 0;
  int n_ml        = 0;
  int n_mr        = 0;
  int n_rot       = 0;

  // Model: raw samples delayed two cycles, accepted level flips after DB consecutive
  // disagreeing cycles, repeats timed from the number of held cycles since the press.
  logic [2:0] m_s1, m_s2, m_db, m_db_prev, m_press;
  int         m_run  [3];
  bit         m_act  [2];
  int         m_n    [2];
  logic [1:0] m_rpt;

  task automatic model_reset();
    m_s1      = 3'b111;
    m_s2      = 3'b111;
    m_db      = 3'b000;
    m_db_prev = 3'b000;
    m_press   = 3'b000;
    m_rpt     = 2'b00;
    for (int k = 0; k < 3; k++) m_run[k] = 0;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      m_n[d]   = 0;
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic [2:0] kn);
    logic [2:0] db_new;
    logic [1:0] eff_old, rpt_new;
    logic       ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    db_new = m_db;
    for (int k = 0; k < 3; k++) begin
      if (~m_s2[k] != m_db[k]) begin
        m_run[k]++;
        if (m_run[k] == int'(DB)) begin
          db_new[k] = ~m_db[k];
          m_run[k]  = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    eff_old[0] = m_press[0] & ~m_press[1];
    eff_old[1] = m_press[1] & ~m_press[0];
    rpt_new    = 2'b00;
`ifdef INPUT_AUTO_REPEAT_EN
    for (int d = 0; d < 2; d++) begin
      ok = m_db[d] & ~m_db[1-d];
      if (m_act[d]) begin
        if (ok) begin
          m_n[d]++;
          rpt_new[d] = (m_n[d] == int'(DAS)) ||
                       (m_n[d] > int'(DAS) && ((m_n[d] - int'(DAS)) % int'(ARR)) == 0);
        end else begin
          m_act[d] = 1'b0;
        end
      end else if (eff_old[d] && ok) begin
        m_act[d] = 1'b1;
        m_n[d]   = 1;
      end
    end
`else
    ok = eff_old[0];
`endif
    m_press   = m_db & ~m_db_prev;
    m_db_prev = m_db;
    m_db      = db_new;
    m_s2      = m_s1;
    m_s1      = kn;
    m_rpt     = rpt_new;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic [2:0] kn);
    resetn = rst_n;
    key_n  = kn;
    @(posedge clk);
    model_edge(rst_n, kn);
    @(negedge clk);
    check("move_left", {2'b00, move_left}, {2'b00, (m_press[1] & ~m_press[0]) | m_rpt[1]});
    check("move_right", {2'b00, move_right}, {2'b00, (m_press[0] & ~m_press[1]) | m_rpt[0]});
    check("rotate", {2'b00, rotate}, {2'b00, m_press[2]});
    check("key_held", key_held, m_db);
    n_ml  += int'(move_left);
    n_mr  += int'(move_right);
    n_rot += int'(rotate);
  endtask

  initial begin
    int base_l, base_r, base_rot;
    int dur;
    logic [2:0] kn;
    logic       rst_n;

    resetn = 1'b0;
    key_n  = 3'b000;
    model_reset();

    // Reset with all keys down; outputs stay quiet, then ROTATE fires at edge 7.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b000);
      check("reset_quiet", {move_left, move_right, rotate}, 3'b000);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 3'b000);
      check("post_reset_rotate", {2'b00, rotate}, {2'b00, logic'(i == 7)});
    end
    for (int i = 0; i < 12; i++) step(1'b1, 3'b111);

    // Bounce on LEFT, then a steady hold.
    base_l = n_ml;
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 3'b101);
      step(1'b1, 3'b101);
      step(1'b1, 3'b111);
    end
    check("bounce_no_pulse", 3'(n_ml - base_l), 3'd0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 3'b101);
      check("bounce_settle", {2'b00, move_left}, {2'b00, logic'(i == 7)});
    end
    for (int i = 0; i < 12; i++) step(1'b1, 3'b111);

    // Clean ROTATE press and release.
    base_rot = n_rot;
    for (int i = 0; i < 20; i++) step(1'b1, 3'b011);
    check("rotate_once", 3'(n_rot - base_rot), 3'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 3'b111);
    check("rotate_no_release_pulse", 3'(n_rot - base_rot), 3'd1);

    // RIGHT held for 40 cycles.
    base_r = n_mr;
    for (int i = 0; i < 40; i++) step(1'b1, 3'b110);
    for (int i = 0; i < 12; i++) step(1'b1, 3'b111);
`ifdef INPUT_AUTO_REPEAT_EN
    check("right_repeat_count", 3'(n_mr - base_r), 3'(11));
`else
    check("right_single_pulse", 3'(n_mr - base_r), 3'd1);
`endif

    // LEFT and RIGHT together, then RIGHT released while LEFT stays down.
    base_l = n_ml;
    base_r = n_mr;
    for (int i = 0; i < 25; i++) step(1'b1, 3'b100);
    check("conflict_no_moves", 3'((n_ml - base_l) + (n_mr - base_r)), 3'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 3'b101);
    check("conflict_left_idle", 3'(n_ml - base_l), 3'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 3'b111);

    // Reset during LEFT auto-repeat with the key still down.
    for (int i = 0; i < 22; i++) step(1'b1, 3'b101);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b101);
      check("mid_reset_quiet", {move_left, move_right, rotate}, 3'b000);
    end
    base_l = n_ml;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 3'b101);
      check("mid_reset_repress", {2'b00, move_left}, {2'b00, logic'(i == 7)});
    end
    check("mid_reset_one_pulse", 3'(n_ml - base_l), 3'd1);

    // Randomized key patterns with occasional short resets.
    for (int i = 0; i < 60; i++) begin
      kn    = 3'($urandom_range(0, 7));
      dur   = int'($urandom_range(1, 18));
      rst_n = ($urandom_range(0, 14) != 0);
      if (!rst_n) dur = 2;
      for (int j = 0; j < dur; j++) step(rst_n, kn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
